// File: rtl/sfp_act_led.sv
// SFP LED driver: per-direction activity blink (fixed on-time, forced off-gap)
// plus debounced link (LOS) and TX-fault status, all inputs synchronized.

module sfp_act_blink #(
    parameter int P_ON_CYC  = 2000000,
    parameter int P_OFF_CYC = 2000000
) (
    input  logic i_clk,
    input  logic i_res_n,
    input  logic i_evt,
    output logic o_led
);
    localparam logic [21:0] ON_LOAD  = 22'(P_ON_CYC - 1);
    localparam logic [21:0] OFF_LOAD = 22'(P_OFF_CYC - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t      state, state_nx;
    logic [21:0] cnt, cnt_nx;
    logic        pend, pend_nx;

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
            o_led <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            pend  <= pend_nx;
            o_led <= (state == ON);
        end
    end

    // The event that starts a pulse from IDLE is consumed; later events
    // inside the on/off window are remembered as a single pending pulse.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pend_nx  = pend;
        case (state)
            IDLE: begin
                if (i_evt) begin
                    state_nx = ON;
                    cnt_nx   = ON_LOAD;
                end
            end
            ON: begin
                if (i_evt) pend_nx = 1'b1;
                if (cnt == '0) begin
                    state_nx = OFF;
                    cnt_nx   = OFF_LOAD;
                end else begin
                    cnt_nx = cnt - 22'd1;
                end
            end
            OFF: begin
                if (cnt == '0) begin
                    if (pend || i_evt) begin
                        state_nx = ON;
                        cnt_nx   = ON_LOAD;
                        pend_nx  = 1'b0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt - 22'd1;
                    if (i_evt) pend_nx = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                pend_nx  = 1'b0;
            end
        endcase
    end
endmodule

module sfp_sts_filt #(
    parameter int   P_STS_FILT = 400000,
    parameter logic P_RST_VAL  = 1'b0
) (
    input  logic i_clk,
    input  logic i_res_n,
    input  logic i_sync,
    output logic o_filt
);
    localparam logic [21:0] LIM = 22'(P_STS_FILT - 1);

    logic [21:0] cnt;

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            o_filt <= P_RST_VAL;
            cnt    <= '0;
        end else if (i_sync == o_filt) begin
            cnt <= '0;
        end else if (cnt == LIM) begin
            o_filt <= i_sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 22'd1;
        end
    end
endmodule

module sfp_act_led #(
    parameter int P_ON_CYC   = 2000000,
    parameter int P_OFF_CYC  = 2000000,
    parameter int P_STS_FILT = 400000
) (
    input  logic       i_clk,
    input  logic       i_res_n,
    input  logic       i_rx_act,
    input  logic       i_tx_act,
    input  logic       i_sfp_los,
    input  logic       i_sfp_txfault,
    output logic [1:0] o_rx_led,
    output logic [1:0] o_tx_led
);
    // bit order: 0 rx_act, 1 tx_act, 2 los, 3 txfault; LOS idles as "no light"
    localparam logic [3:0] SYNC_RST = 4'b0100;

    logic [3:0] raw, sync1, sync2;
    logic [1:0] prev, act_evt, act_led, sts_filt, sts_q;

    assign raw = {i_sfp_txfault, i_sfp_los, i_tx_act, i_rx_act};

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            sync1 <= SYNC_RST;
            sync2 <= SYNC_RST;
            prev  <= SYNC_RST[1:0];
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= sync2[1:0];
        end
    end

    assign act_evt = sync2[1:0] ^ prev;

    for (genvar g = 0; g < 2; g++) begin : g_act
        sfp_act_blink #(
            .P_ON_CYC (P_ON_CYC),
            .P_OFF_CYC(P_OFF_CYC)
        ) u_blink (
            .i_clk  (i_clk),
            .i_res_n(i_res_n),
            .i_evt  (act_evt[g]),
            .o_led  (act_led[g])
        );
    end

    for (genvar g = 0; g < 2; g++) begin : g_sts
        sfp_sts_filt #(
            .P_STS_FILT(P_STS_FILT),
            .P_RST_VAL (SYNC_RST[2+g])
        ) u_filt (
            .i_clk  (i_clk),
            .i_res_n(i_res_n),
            .i_sync (sync2[2+g]),
            .o_filt (sts_filt[g])
        );
    end

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            sts_q <= 2'b00;
        end else begin
            sts_q[0] <= ~sts_filt[0];
            sts_q[1] <= sts_filt[1];
        end
    end

    assign o_rx_led = {sts_q[0], act_led[0]};
    assign o_tx_led = {sts_q[1], act_led[1]};
endmodule

// File: tb/tb_sfp_act_led.sv
// Randomized + directed bench for sfp_act_led against a pulse-window /
// sample-history reference model.

module tb_sfp_act_led;
    localparam int ON   = 4;
    localparam int OFF  = 3;
    localparam int FILT = 5;
    localparam int HD   = 8;

    logic       i_clk = 1'b0;
    logic       i_res_n, i_rx_act, i_tx_act, i_sfp_los, i_sfp_txfault;
    logic [1:0] o_rx_led, o_tx_led;

    sfp_act_led #(.P_ON_CYC(ON), .P_OFF_CYC(OFF), .P_STS_FILT(FILT)) dut (
        .i_clk        (i_clk),
        .i_res_n      (i_res_n),
        .i_rx_act     (i_rx_act),
        .i_tx_act     (i_tx_act),
        .i_sfp_los    (i_sfp_los),
        .i_sfp_txfault(i_sfp_txfault),
        .o_rx_led     (o_rx_led),
        .o_tx_led     (o_tx_led)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // reference state: input captures per edge, pulse windows, filtered levels
    bit cap [4][HD];
    bit act_on [2];
    int s_start [2];
    bit pend [2];
    bit filt [2];
    bit exp_b [2];
    bit exp_s [2];
    logic [1:0] hrx [64];
    logic [1:0] htx [64];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < HD; i++) cap[c][i] = (c == 2);
        for (int d = 0; d < 2; d++) begin
            act_on[d] = 0;
            pend[d]   = 0;
            s_start[d] = 0;
        end
        filt[0] = 1;
        filt[1] = 0;
    endtask

    task automatic blink_step(input int d, input bit ev);
        if (act_on[d]) begin
            if (cyc == s_start[d] + ON + OFF) begin
                if (pend[d] || ev) begin
                    s_start[d] = cyc;
                    pend[d]    = 0;
                end else begin
                    act_on[d] = 0;
                end
            end else if (ev) begin
                pend[d] = 1;
            end
        end else if (ev) begin
            act_on[d]  = 1;
            s_start[d] = cyc;
            pend[d]    = 0;
        end
    endtask

    task automatic tick();
        bit in_v [4];
        bit all_diff;
        @(posedge i_clk);
        cyc++;
        in_v = '{i_rx_act, i_tx_act, i_sfp_los, i_sfp_txfault};
        if (!i_res_n) begin
            model_reset();
            exp_b = '{0, 0};
            exp_s = '{0, 0};
        end else begin
            for (int d = 0; d < 2; d++)
                exp_b[d] = act_on[d] && ((cyc - 1 - s_start[d]) < ON);
            exp_s[0] = !filt[0];
            exp_s[1] = filt[1];
            for (int c = 0; c < 4; c++) begin
                for (int i = HD - 1; i > 0; i--) cap[c][i] = cap[c][i-1];
                cap[c][0] = in_v[c];
            end
            // an edge captured at e-3 -> e-2 is seen as an event at edge e
            for (int d = 0; d < 2; d++) blink_step(d, cap[d][2] != cap[d][3]);
            // level follows after FILT consecutive synchronized samples disagree
            for (int f = 0; f < 2; f++) begin
                all_diff = 1;
                for (int i = 2; i < 2 + FILT; i++)
                    if (cap[2+f][i] == filt[f]) all_diff = 0;
                if (all_diff) filt[f] = !filt[f];
            end
        end
        #1;
        chk("rx_blink", o_rx_led[0], exp_b[0]);
        chk("tx_blink", o_tx_led[0], exp_b[1]);
        chk("rx_link",  o_rx_led[1], exp_s[0]);
        chk("tx_fault", o_tx_led[1], exp_s[1]);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (i < 64) begin
                hrx[i] = o_rx_led;
                htx[i] = o_tx_led;
            end
        end
    endtask

    task automatic do_reset();
        i_res_n = 1'b0;
        #1;
        chk("rst_async_rx", o_rx_led, 2'b00);
        chk("rst_async_tx", o_tx_led, 2'b00);
        model_reset();
        run(3);
        i_res_n = 1'b1;
    endtask

    // two rx toggles d cycles apart; expect 4 on, 3 off, 4 on
    task automatic rx_pair(input string tag, input int d);
        int a, l1, g, l2;
        for (int i = 0; i < 24; i++) begin
            if (i == 0 || i == d) i_rx_act = !i_rx_act;
            tick();
            hrx[i] = o_rx_led;
        end
        a = 0;
        while (a < 23 && hrx[a][0] == 1'b0) a++;
        l1 = 0; while (a < 23 && hrx[a][0] == 1'b1) begin l1++; a++; end
        g  = 0; while (a < 23 && hrx[a][0] == 1'b0) begin g++;  a++; end
        l2 = 0; while (a < 23 && hrx[a][0] == 1'b1) begin l2++; a++; end
        chk({tag, "_len1"}, l1, ON);
        chk({tag, "_gap"},  g,  OFF);
        chk({tag, "_len2"}, l2, ON);
    endtask

    initial begin
        int idx, cnt, dens_rx, dens_tx;
        i_res_n = 1'b1;
        i_rx_act = 0; i_tx_act = 0; i_sfp_los = 0; i_sfp_txfault = 0;
        model_reset();
        #2 i_res_n = 1'b0;
        #1;
        chk("rst_rx", o_rx_led, 2'b00);
        chk("rst_tx", o_tx_led, 2'b00);
        run(3);
        i_res_n = 1'b1;

        // reset release: link comes up once LOS-low passes sync + filter
        run(14);
        idx = 0;
        while (idx < 13 && hrx[idx][1] == 1'b0) idx++;
        chk("los_accept_cyc", idx, 7);
        chk("idle_rx_blink", hrx[13][0], 1'b0);

        // single rx rise
        i_rx_act = 1;
        run(12);
        idx = 0;
        while (idx < 11 && hrx[idx][0] == 1'b0) idx++;
        chk("rx_first_cyc", idx, 3);
        cnt = 0;
        for (int i = 0; i < 12; i++) cnt += hrx[i][0];
        chk("rx_on_len", cnt, ON);
        cnt = 0;
        for (int i = 0; i < 12; i++) cnt += htx[i][0];
        chk("tx_quiet", cnt, 0);

        // continuous tx activity then stop
        for (int i = 0; i < 40; i++) begin
            i_tx_act = !i_tx_act;
            tick();
        end
        run(16);
        chk("tx_settled", htx[15][0], 1'b0);

        // event in off-gap, then event during on (pending)
        rx_pair("gap_evt", 5);
        run(4);
        rx_pair("on_evt", 1);
        run(4);

        // LOS glitch of 4 cycles is filtered out
        i_sfp_los = 1;
        run(4);
        i_sfp_los = 0;
        run(14);
        cnt = 0;
        for (int i = 0; i < 14; i++) cnt += !hrx[i][1];
        chk("los_glitch_drop", cnt, 0);

        // LOS high for 6 cycles drops link 7 cycles after the rise
        i_sfp_los = 1;
        for (int i = 0; i < 14; i++) begin
            if (i == 6) i_sfp_los = 0;
            tick();
            hrx[i] = o_rx_led;
        end
        idx = 0;
        while (idx < 13 && hrx[idx][1] == 1'b1) idx++;
        chk("los_drop_cyc", idx, 7);
        run(12);

        // reset in the middle of an on pulse (rx ends low, no edge after release)
        i_rx_act = 0;
        run(12);
        i_rx_act = 1;
        tick();
        i_rx_act = 0;
        run(4);
        chk("pre_rst_on", o_rx_led[0], 1'b1);
        do_reset();
        run(12);
        cnt = 0;
        for (int i = 0; i < 12; i++) cnt += hrx[i][0];
        chk("post_rst_quiet", cnt, 0);

        // randomized traffic with varying density, one reset mid-run
        dens_rx = 0;
        dens_tx = 0;
        for (int i = 0; i < 800; i++) begin
            if (i % 40 == 0) begin
                dens_rx = $urandom_range(0, 5);
                dens_tx = $urandom_range(0, 5);
            end
            if ($urandom_range(0, 7) < dens_rx) i_rx_act = !i_rx_act;
            if ($urandom_range(0, 7) < dens_tx) i_tx_act = !i_tx_act;
            if ($urandom_range(0, 11) == 0) i_sfp_los = !i_sfp_los;
            if ($urandom_range(0, 11) == 0) i_sfp_txfault = !i_sfp_txfault;
            if (i == 400) do_reset();
            tick();
        end
        i_rx_act = 0; i_tx_act = 0; i_sfp_los = 0; i_sfp_txfault = 0;
        run(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
